mac_dot_seq: RTL

Sequencer that drives one mac_int_fsm instance to compute signed 8x8 dot products of programmable length. Operand pairs stream into a local FIFO. On start, the block clears the MAC and issues one valid pulse per pair, waiting for the MAC's done before each next pulse. It reports the final 16-bit sum, sticky overflow and a timeout error. It sits between the operand source and the MAC, and owns the MAC's reset, valid and A/B inputs.

---
 rtl/mac_dot_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mac_dot_seq.sv
// mac_dot_seq: sequences one mac_int_fsm through a signed 8x8 dot product of
// programmable length.
//   clk, reset          : clock, synchronous active-high reset
//   start, len          : job request (sampled in IDLE only) and pair count
//   in_valid/in_ready,
//   in_a, in_b          : operand-pair stream into the local FIFO
//   mac_clr, mac_valid,
//   mac_a, mac_b        : drive the MAC (clear, one product request, operands)
//   mac_y, mac_overflow,
//   mac_done            : MAC accumulator, sticky overflow, completion pulse
//   busy                : high whenever a job is in flight
//   res_valid, res_y,
//   res_overflow,
//   res_error           : result strobe, sum, overflow seen, timeout abort
module mac_dot_seq #(
  parameter int DEPTH   = 8,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             mac_clr,
  output logic             mac_valid,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  input  logic [15:0]      mac_y,
  input  logic             mac_overflow,
  input  logic             mac_done,
  output logic             busy,
  output logic             res_valid,
  output logic [15:0]      res_y,
  output logic             res_overflow,
  output logic             res_error
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, DRAIN, DONE} state_t;

  state_t           state, state_n;
  pair_t            mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [LEN_W-1:0] remaining;
  logic [TW-1:0]    timer;
  logic             push, pop, empty, go, issue, capture, expire;

  // ---------------- operand FIFO ----------------
  // in_ready looks only at the registered count, so a pop in the same cycle
  // never opens a slot for a push until the following cycle.
  assign empty    = (count == '0);
  assign in_ready = (count != (AW+1)'(DEPTH));
  assign push     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pair_t'{a: in_a, b: in_b};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  assign go = (state == IDLE) && start;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    case (state)
      IDLE:  if (start) state_n = (len == '0) ? DONE : CLEAR;
      CLEAR: state_n = FEED;
      FEED: if (!empty) begin
        pop     = 1'b1;
        issue   = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        // done wins over a timeout landing on the same cycle
        if (mac_done) begin
          capture = 1'b1;
          state_n = (remaining == '0) ? DONE : FEED;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          expire  = 1'b1;
          state_n = (remaining == '0) ? DONE : DRAIN;
        end
      end
      // discard the rest of an aborted job so the next job starts aligned
      DRAIN: if (!empty) begin
        pop = 1'b1;
        if (remaining == LEN_W'(1)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign mac_clr   = (state == CLEAR);
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining    <= '0;
      timer        <= '0;
      mac_valid    <= 1'b0;
      mac_a        <= '0;
      mac_b        <= '0;
      res_y        <= '0;
      res_overflow <= 1'b0;
      res_error    <= 1'b0;
    end else begin
      mac_valid <= issue;
      if (issue) begin
        mac_a <= mem[rd_ptr].a;
        mac_b <= mem[rd_ptr].b;
      end
      if (go) begin
        remaining    <= len;
        res_y        <= '0;
        res_overflow <= 1'b0;
        res_error    <= 1'b0;
      end else if (pop) begin
        remaining <= remaining - LEN_W'(1);
      end
      if (issue)              timer <= '0;
      else if (state == WAIT) timer <= timer + TW'(1);
      if (capture) begin
        res_y        <= mac_y;
        res_overflow <= res_overflow | mac_overflow;
      end
      if (expire) res_error <= 1'b1;
    end
  end
endmodule
